// File: rtl/alu_arbitro.sv
// -----------------------------------------------------------------------------
// alu_arbitro
//
// Shares one combinational alu between two requesters. A round-robin arbiter
// picks one request at a time, registers its opcode and operands onto the alu
// inputs, holds them for CICLOS_EXEC cycles, then captures the alu result and
// flags. These are returned on a valid/listo response port, tagged with the
// id of the requester that issued the operation.
//
// Optional feature (macro ALU_ARB_ESTAD_EN):
//   Adds two saturating counters, cnt_conc0/cnt_conc1, that count accepted
//   operations per requester. With the macro undefined, these counters and
//   their ports are absent.
//
// Parameters:
//   ANCHO        operand width; the result is 2*ANCHO bits wide
//   CICLOS_EXEC  cycles the alu inputs are held before capture (>= 1)
//   ANCHO_CNT    statistics counter width (only with ALU_ARB_ESTAD_EN)
//
// Ports:
//   reloj, reinicio              clock (rising edge), synchronous active-high reset
//   reqN_valido / reqN_listo     request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_dato0/1        opcode and operands for requester N
//   alu_Codigo_OP, alu_Dato0/1   registered drive to the alu
//   alu_Resultado, alu_banderaA/B  alu outputs, captured at the end of execution
//   resp_valido / resp_listo     response handshake
//   resp_id                      requester that issued the returned operation
//   resp_Resultado, resp_banderaA/B  captured alu result and flags
//   cnt_conc0/1                  accepted-operation counters (optional)
// -----------------------------------------------------------------------------
module alu_arbitro #(
   parameter int ANCHO       = 8,
   parameter int CICLOS_EXEC = 1
`ifdef ALU_ARB_ESTAD_EN
   , parameter int ANCHO_CNT = 16
`endif
) (
   input  logic               reloj,
   input  logic               reinicio,
   input  logic               req0_valido,
   output logic               req0_listo,
   input  logic [2:0]         req0_op,
   input  logic [ANCHO-1:0]   req0_dato0,
   input  logic [ANCHO-1:0]   req0_dato1,
   input  logic               req1_valido,
   output logic               req1_listo,
   input  logic [2:0]         req1_op,
   input  logic [ANCHO-1:0]   req1_dato0,
   input  logic [ANCHO-1:0]   req1_dato1,
   output logic [2:0]         alu_Codigo_OP,
   output logic [ANCHO-1:0]   alu_Dato0,
   output logic [ANCHO-1:0]   alu_Dato1,
   input  logic [2*ANCHO-1:0] alu_Resultado,
   input  logic               alu_banderaA,
   input  logic               alu_banderaB,
   output logic               resp_valido,
   input  logic               resp_listo,
   output logic               resp_id,
   output logic [2*ANCHO-1:0] resp_Resultado,
   output logic               resp_banderaA,
   output logic               resp_banderaB
`ifdef ALU_ARB_ESTAD_EN
   , output logic [ANCHO_CNT-1:0] cnt_conc0
   , output logic [ANCHO_CNT-1:0] cnt_conc1
`endif
);

   typedef enum logic [1:0] {LIBRE, EJEC, RESP} estado_t;

   // The execution counter must hold CICLOS_EXEC-1; keep it at least 1 bit wide.
   localparam int              CNT_W   = (CICLOS_EXEC > 1) ? $clog2(CICLOS_EXEC) : 1;
   localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(CICLOS_EXEC - 1);

   estado_t          estado;
   logic             ultimo;     // requester granted most recently
   logic             id_q;       // requester that owns the operation in flight
   logic [CNT_W-1:0] cnt;
   logic             grant_any;
   logic             grant_id;
   logic             acepta;

   // Round-robin arbitration: a lone request wins outright; on a tie, the
   // requester that was not served last wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      grant_any = req0_valido | req1_valido;
      grant_id  = 1'b0;
      if (req0_valido && req1_valido)
         grant_id = ~ultimo;
      else if (req1_valido)
         grant_id = 1'b1;
   end

   // Suppress acceptance while reinicio is high. The reset edge discards
   // whatever would have been latched, so signalling listo would lie to the
   // requester.
   assign acepta     = (estado == LIBRE) && !reinicio && grant_any;
   assign req0_listo = acepta && !grant_id;
   assign req1_listo = acepta &&  grant_id;

   always_ff @(posedge reloj) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values present before the edge.
      if (reinicio) begin
         estado         <= LIBRE;
         ultimo         <= 1'b1;
         id_q           <= 1'b0;
         cnt            <= '0;
         alu_Codigo_OP  <= '0;
         alu_Dato0      <= '0;
         alu_Dato1      <= '0;
         resp_valido    <= 1'b0;
         resp_id        <= 1'b0;
         resp_Resultado <= '0;
         resp_banderaA  <= 1'b0;
         resp_banderaB  <= 1'b0;
      end else begin
         case (estado)
            LIBRE: begin
               if (acepta) begin
                  alu_Codigo_OP <= grant_id ? req1_op    : req0_op;
                  alu_Dato0     <= grant_id ? req1_dato0 : req0_dato0;
                  alu_Dato1     <= grant_id ? req1_dato1 : req0_dato1;
                  ultimo        <= grant_id;
                  id_q          <= grant_id;
                  cnt           <= CNT_INI;
                  estado        <= EJEC;
               end
            end
            EJEC: begin
               // The alu inputs stay untouched here. The result is sampled
               // once they have been stable for CICLOS_EXEC cycles.
               if (cnt == '0) begin
                  resp_Resultado <= alu_Resultado;
                  resp_banderaA  <= alu_banderaA;
                  resp_banderaB  <= alu_banderaB;
                  resp_id        <= id_q;
                  resp_valido    <= 1'b1;
                  estado         <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_listo) begin
                  resp_valido <= 1'b0;
                  estado      <= LIBRE;
               end
            end
            default: estado <= LIBRE;
         endcase
      end
   end

`ifdef ALU_ARB_ESTAD_EN
   // Per-requester accepted-operation counters. Each counter saturates at
   // all-ones instead of wrapping.
   always_ff @(posedge reloj) begin
      if (reinicio) begin
         cnt_conc0 <= '0;
         cnt_conc1 <= '0;
      end else begin
         if (req0_listo && (cnt_conc0 != '1))
            cnt_conc0 <= cnt_conc0 + 1'b1;
         if (req1_listo && (cnt_conc1 != '1))
            cnt_conc1 <= cnt_conc1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbitro.sv
// -----------------------------------------------------------------------------
// tb_alu_arbitro
//
// Directed bench for alu_arbitro. Instance "dut" uses CICLOS_EXEC=1 and
// instance "dut3" uses CICLOS_EXEC=3; with ALU_ARB_ESTAD_EN defined, dut3 also
// uses ANCHO_CNT=2. Each instance has a stub alu:
//   Resultado = Dato0 + Dato1 (zero-extended)
//   banderaA  = (Resultado == 0)
//   banderaB  = carry out of the low ANCHO bits
// Both instances share the clock and reset.
// -----------------------------------------------------------------------------
module tb_alu_arbitro;

   localparam int ANCHO = 8;

   logic reloj = 1'b0;
   logic reinicio = 1'b1;
   always #5 reloj = ~reloj;

   int vectors = 0;
   int miscompares = 0;

   // ---- instance A (CICLOS_EXEC = 1) ----
   logic req0_valido, req0_listo, req1_valido, req1_listo;
   logic [2:0] req0_op, req1_op, alu_Codigo_OP;
   logic [ANCHO-1:0] req0_dato0, req0_dato1, req1_dato0, req1_dato1, alu_Dato0, alu_Dato1;
   logic [2*ANCHO-1:0] alu_Resultado, resp_Resultado;
   logic alu_banderaA, alu_banderaB, resp_valido, resp_listo, resp_id, resp_banderaA, resp_banderaB;

   // ---- instance B (CICLOS_EXEC = 3) ----
   logic b_req0_valido, b_req0_listo, b_req1_valido, b_req1_listo;
   logic [2:0] b_req0_op, b_req1_op, b_alu_Codigo_OP;
   logic [ANCHO-1:0] b_req0_dato0, b_req0_dato1, b_req1_dato0, b_req1_dato1, b_alu_Dato0, b_alu_Dato1;
   logic [2*ANCHO-1:0] b_alu_Resultado, b_resp_Resultado;
   logic b_alu_banderaA, b_alu_banderaB, b_resp_valido, b_resp_listo, b_resp_id, b_resp_banderaA, b_resp_banderaB;

`ifdef ALU_ARB_ESTAD_EN
   logic [15:0] cnt_conc0, cnt_conc1;
   logic [1:0]  b_cnt_conc0, b_cnt_conc1;
`endif

   // Stub alus.
   assign alu_Resultado   = (2*ANCHO)'(alu_Dato0) + (2*ANCHO)'(alu_Dato1);
   assign alu_banderaA    = (alu_Resultado == '0);
   assign alu_banderaB    = alu_Resultado[ANCHO];
   assign b_alu_Resultado = (2*ANCHO)'(b_alu_Dato0) + (2*ANCHO)'(b_alu_Dato1);
   assign b_alu_banderaA  = (b_alu_Resultado == '0);
   assign b_alu_banderaB  = b_alu_Resultado[ANCHO];

   alu_arbitro #(.ANCHO(ANCHO), .CICLOS_EXEC(1)) dut (
      .reloj(reloj), .reinicio(reinicio),
      .req0_valido(req0_valido), .req0_listo(req0_listo), .req0_op(req0_op),
      .req0_dato0(req0_dato0), .req0_dato1(req0_dato1),
      .req1_valido(req1_valido), .req1_listo(req1_listo), .req1_op(req1_op),
      .req1_dato0(req1_dato0), .req1_dato1(req1_dato1),
      .alu_Codigo_OP(alu_Codigo_OP), .alu_Dato0(alu_Dato0), .alu_Dato1(alu_Dato1),
      .alu_Resultado(alu_Resultado), .alu_banderaA(alu_banderaA), .alu_banderaB(alu_banderaB),
      .resp_valido(resp_valido), .resp_listo(resp_listo), .resp_id(resp_id),
      .resp_Resultado(resp_Resultado), .resp_banderaA(resp_banderaA), .resp_banderaB(resp_banderaB)
`ifdef ALU_ARB_ESTAD_EN
      , .cnt_conc0(cnt_conc0), .cnt_conc1(cnt_conc1)
`endif
   );

   alu_arbitro #(.ANCHO(ANCHO), .CICLOS_EXEC(3)
`ifdef ALU_ARB_ESTAD_EN
      , .ANCHO_CNT(2)
`endif
   ) dut3 (
      .reloj(reloj), .reinicio(reinicio),
      .req0_valido(b_req0_valido), .req0_listo(b_req0_listo), .req0_op(b_req0_op),
      .req0_dato0(b_req0_dato0), .req0_dato1(b_req0_dato1),
      .req1_valido(b_req1_valido), .req1_listo(b_req1_listo), .req1_op(b_req1_op),
      .req1_dato0(b_req1_dato0), .req1_dato1(b_req1_dato1),
      .alu_Codigo_OP(b_alu_Codigo_OP), .alu_Dato0(b_alu_Dato0), .alu_Dato1(b_alu_Dato1),
      .alu_Resultado(b_alu_Resultado), .alu_banderaA(b_alu_banderaA), .alu_banderaB(b_alu_banderaB),
      .resp_valido(b_resp_valido), .resp_listo(b_resp_listo), .resp_id(b_resp_id),
      .resp_Resultado(b_resp_Resultado), .resp_banderaA(b_resp_banderaA), .resp_banderaB(b_resp_banderaB)
`ifdef ALU_ARB_ESTAD_EN
      , .cnt_conc0(b_cnt_conc0), .cnt_conc1(b_cnt_conc1)
`endif
   );

   // Advance to just after the next rising edge.
   task tick;
      @(posedge reloj);
      #1;
   endtask

   task idle_inputs;
      req0_valido = 0; req0_op = '0; req0_dato0 = '0; req0_dato1 = '0;
      req1_valido = 0; req1_op = '0; req1_dato0 = '0; req1_dato1 = '0;
      b_req0_valido = 0; b_req0_op = '0; b_req0_dato0 = '0; b_req0_dato1 = '0;
      b_req1_valido = 0; b_req1_op = '0; b_req1_dato0 = '0; b_req1_dato1 = '0;
      resp_listo = 1; b_resp_listo = 1;
   endtask

   task apply_reset;
      idle_inputs();
      reinicio = 1;
      tick();
      tick();
      reinicio = 0;
   endtask

   task test_reset;
      idle_inputs();
      reinicio = 1;
      req0_valido = 1;
      req1_valido = 1;
      tick();
      tick();
      vectors++; if (req0_listo !== 1'b0 || req1_listo !== 1'b0) begin miscompares++; $display("FAIL reset_listo got %b%b exp 00", req0_listo, req1_listo); end
      vectors++; if (resp_valido !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valido got %b exp 0", resp_valido); end
      vectors++; if (alu_Codigo_OP !== 3'd0 || alu_Dato0 !== 8'd0 || alu_Dato1 !== 8'd0) begin miscompares++; $display("FAIL reset_alu got %h %h %h exp 0 0 0", alu_Codigo_OP, alu_Dato0, alu_Dato1); end
      vectors++; if (resp_Resultado !== 16'd0 || resp_id !== 1'b0 || resp_banderaA !== 1'b0 || resp_banderaB !== 1'b0) begin miscompares++; $display("FAIL reset_resp got %h %b %b %b exp 0", resp_Resultado, resp_id, resp_banderaA, resp_banderaB); end
      vectors++; if (b_resp_valido !== 1'b0 || b_alu_Codigo_OP !== 3'd0) begin miscompares++; $display("FAIL reset_b got %b %h exp 0 0", b_resp_valido, b_alu_Codigo_OP); end
      req0_valido = 0;
      req1_valido = 0;
      reinicio = 0;
      tick();
   endtask

   task test_single;
      req0_op = 3'b010; req0_dato0 = 8'd16; req0_dato1 = 8'd55; resp_listo = 1;
      req0_valido = 1;
      #1;
      vectors++; if (req0_listo !== 1'b1 || req1_listo !== 1'b0) begin miscompares++; $display("FAIL single_listo got %b%b exp 10", req0_listo, req1_listo); end
      tick();
      req0_valido = 0;
      vectors++; if (alu_Codigo_OP !== 3'd2 || alu_Dato0 !== 8'd16 || alu_Dato1 !== 8'd55) begin miscompares++; $display("FAIL single_alu got %h %0d %0d exp 2 16 55", alu_Codigo_OP, alu_Dato0, alu_Dato1); end
      vectors++; if (resp_valido !== 1'b0) begin miscompares++; $display("FAIL single_early_resp got %b exp 0", resp_valido); end
      tick();
      vectors++; if (resp_valido !== 1'b1) begin miscompares++; $display("FAIL single_resp_valido got %b exp 1", resp_valido); end
      vectors++; if (resp_Resultado !== 16'd71 || resp_id !== 1'b0 || resp_banderaA !== 1'b0) begin miscompares++; $display("FAIL single_resp got %0d id %b fA %b exp 71 0 0", resp_Resultado, resp_id, resp_banderaA); end
      tick();
      vectors++; if (resp_valido !== 1'b0) begin miscompares++; $display("FAIL single_resp_drop got %b exp 0", resp_valido); end
   endtask

   task test_round_robin;
      int grants[$];
      int rids[$];
      bit both;
      both = 0;
      apply_reset();
      req0_op = 3'd1; req0_dato0 = 8'd1; req0_dato1 = 8'd2;
      req1_op = 3'd4; req1_dato0 = 8'd3; req1_dato1 = 8'd4;
      req0_valido = 1; req1_valido = 1; resp_listo = 1;
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
         #1;
         if (req0_listo && req1_listo) both = 1;
         if (req0_listo) grants.push_back(0);
         else if (req1_listo) grants.push_back(1);
         if (resp_valido) rids.push_back(int'(resp_id));
         tick();
      end
      req0_valido = 0; req1_valido = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (resp_valido) begin
            rids.push_back(int'(resp_id));
            vectors++; if (resp_Resultado !== (resp_id ? 16'd7 : 16'd3)) begin miscompares++; $display("FAIL rr_last_result got %0d id %b", resp_Resultado, resp_id); end
         end
         tick();
      end
      vectors++; if (both !== 1'b0) begin miscompares++; $display("FAIL rr_both_listo got 1 exp 0"); end
      vectors++; if (grants.size() != 4) begin miscompares++; $display("FAIL rr_grant_count got %0d exp 4", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         vectors++; if (grants[i] != i % 2) begin miscompares++; $display("FAIL rr_grant_%0d got %0d exp %0d", i, grants[i], i % 2); end
      end
      vectors++; if (rids.size() != 4) begin miscompares++; $display("FAIL rr_resp_count got %0d exp 4", rids.size()); end
      for (int i = 0; i < rids.size(); i++) begin
         vectors++; if (rids[i] != i % 2) begin miscompares++; $display("FAIL rr_resp_id_%0d got %0d exp %0d", i, rids[i], i % 2); end
      end
   endtask

   task test_resp_stall;
      resp_listo = 0;
      req1_op = 3'b111; req1_dato0 = 8'd200; req1_dato1 = 8'd100;
      req1_valido = 1;
      #1;
      vectors++; if (req1_listo !== 1'b1) begin miscompares++; $display("FAIL stall_grant got %b exp 1", req1_listo); end
      tick();
      req1_valido = 0;
      tick();
      for (int c = 0; c < 5; c++) begin
         req0_valido = 1; req1_valido = 1;
         #1;
         vectors++; if (resp_valido !== 1'b1) begin miscompares++; $display("FAIL stall_valido_%0d got %b exp 1", c, resp_valido); end
         vectors++; if (resp_Resultado !== 16'd300 || resp_id !== 1'b1 || resp_banderaB !== 1'b1 || resp_banderaA !== 1'b0) begin miscompares++; $display("FAIL stall_resp_%0d got %0d %b %b %b exp 300 1 0 1", c, resp_Resultado, resp_id, resp_banderaA, resp_banderaB); end
         vectors++; if (req0_listo !== 1'b0 || req1_listo !== 1'b0) begin miscompares++; $display("FAIL stall_listo_%0d got %b%b exp 00", c, req0_listo, req1_listo); end
         tick();
      end
      req0_valido = 0; req1_valido = 0;
      resp_listo = 1;
      tick();
      vectors++; if (resp_valido !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b exp 0", resp_valido); end
      req0_valido = 1;
      #1;
      vectors++; if (req0_listo !== 1'b1) begin miscompares++; $display("FAIL stall_libre got %b exp 1", req0_listo); end
      req0_valido = 0;
      tick();
   endtask

   task test_exec3;
      b_resp_listo = 1;
      b_req1_op = 3'b101; b_req1_dato0 = 8'd0; b_req1_dato1 = 8'd0;
      b_req1_valido = 1;
      #1;
      vectors++; if (b_req1_listo !== 1'b1 || b_req0_listo !== 1'b0) begin miscompares++; $display("FAIL exec3_grant got %b%b exp 01", b_req0_listo, b_req1_listo); end
      tick();
      b_req1_valido = 0;
      for (int k = 0; k < 3; k++) begin
         vectors++; if (b_alu_Codigo_OP !== 3'd5 || b_alu_Dato0 !== 8'd0 || b_alu_Dato1 !== 8'd0) begin miscompares++; $display("FAIL exec3_alu_%0d got %h %h %h exp 5 0 0", k, b_alu_Codigo_OP, b_alu_Dato0, b_alu_Dato1); end
         vectors++; if (b_resp_valido !== 1'b0) begin miscompares++; $display("FAIL exec3_early_%0d got %b exp 0", k, b_resp_valido); end
         tick();
      end
      vectors++; if (b_resp_valido !== 1'b1) begin miscompares++; $display("FAIL exec3_valido got %b exp 1", b_resp_valido); end
      vectors++; if (b_resp_Resultado !== 16'd0 || b_resp_banderaA !== 1'b1 || b_resp_id !== 1'b1) begin miscompares++; $display("FAIL exec3_resp got %0d fA %b id %b exp 0 1 1", b_resp_Resultado, b_resp_banderaA, b_resp_id); end
      tick();
   endtask

   task test_reset_mid;
      req0_op = 3'b011; req0_dato0 = 8'd9; req0_dato1 = 8'd9;
      req0_valido = 1;
      tick();
      req0_valido = 0;
      reinicio = 1;
      tick();
      vectors++; if (resp_valido !== 1'b0 || resp_Resultado !== 16'd0 || resp_id !== 1'b0 || resp_banderaA !== 1'b0) begin miscompares++; $display("FAIL midrst_resp got %b %0d %b %b exp 0", resp_valido, resp_Resultado, resp_id, resp_banderaA); end
      vectors++; if (alu_Codigo_OP !== 3'd0 || alu_Dato0 !== 8'd0 || alu_Dato1 !== 8'd0) begin miscompares++; $display("FAIL midrst_alu got %h %h %h exp 0", alu_Codigo_OP, alu_Dato0, alu_Dato1); end
      reinicio = 0;
      tick();
      tick();
      vectors++; if (resp_valido !== 1'b0) begin miscompares++; $display("FAIL midrst_ghost got %b exp 0", resp_valido); end
      req0_valido = 1; req1_valido = 1;
      #1;
      vectors++; if (req0_listo !== 1'b1 || req1_listo !== 1'b0) begin miscompares++; $display("FAIL midrst_grant got %b%b exp 10", req0_listo, req1_listo); end
      req0_valido = 0; req1_valido = 0;
      tick();
   endtask

`ifdef ALU_ARB_ESTAD_EN
   function automatic logic sel_listo(input bit on_b, input bit id);
      if (on_b) return id ? b_req1_listo : b_req0_listo;
      return id ? req1_listo : req0_listo;
   endfunction

   // Issues one operation and consumes its response; an expired wait counts as a miscompare.
   task automatic run_op(input bit on_b, input bit id);
      int budget;
      if (on_b) begin if (id) b_req1_valido = 1; else b_req0_valido = 1; end
      else      begin if (id) req1_valido = 1;   else req0_valido = 1;   end
      budget = 0;
      #1;
      while (!sel_listo(on_b, id) && budget < 20) begin tick(); #1; budget++; end
      vectors++; if (budget >= 20) begin miscompares++; $display("FAIL stats_grant_timeout dut %0d id %0d", on_b, id); end
      tick();
      b_req0_valido = 0; b_req1_valido = 0; req0_valido = 0; req1_valido = 0;
      budget = 0;
      while (!(on_b ? b_resp_valido : resp_valido) && budget < 20) begin tick(); budget++; end
      vectors++; if (budget >= 20) begin miscompares++; $display("FAIL stats_resp_timeout dut %0d id %0d", on_b, id); end
      tick();
   endtask

   task test_stats;
      run_op(0, 0); run_op(0, 1); run_op(0, 0); run_op(0, 1); run_op(0, 0);
      vectors++; if (cnt_conc0 !== 16'd3 || cnt_conc1 !== 16'd2) begin miscompares++; $display("FAIL stats_counts got %0d %0d exp 3 2", cnt_conc0, cnt_conc1); end
      for (int i = 0; i < 5; i++) run_op(1, 0);
      vectors++; if (b_cnt_conc0 !== 2'd3 || b_cnt_conc1 !== 2'd0) begin miscompares++; $display("FAIL stats_saturate got %0d %0d exp 3 0", b_cnt_conc0, b_cnt_conc1); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_resp_stall();
      test_exec3();
      test_reset_mid();
`ifdef ALU_ARB_ESTAD_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
